// File: rtl/pattern_merge_pipe_if.sv
// Handshake bundle for pattern_merge_pipe: input transaction side and output result side.
interface pattern_merge_pipe_if #(
  parameter int CH = 4,
  parameter int W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mode;
  logic [CH*W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [2*CH-1:0]   out_data;
  logic              out_flag;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flag
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flag
  );
endinterface

// File: rtl/pattern_merge_pipe.sv
// Per-channel left/right pattern merge feeding a DEPTH-stage elastic valid/ready pipeline.
// Optional output MISR signature enabled by defining PATTERN_MERGE_MISR_EN.

module pattern_merge_lane #(
  parameter int W = 5
) (
  input  logic [1:0]   mode,
  input  logic [W-1:0] x,
  output logic         a,
  output logic         b
);
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    case (mode)
      2'd0: begin a = ~|x;                  b = ~&x;                    end
      2'd1: begin a = ^x;                   b = x[0] & x[W-1];          end
      2'd2: begin a = ~(x[0] & x[1]);       b = ~(x[W-1] | x[W-2]);     end
      default: begin a = ^x;                b = ~|x;                    end
    endcase
  end
endmodule

module pattern_merge_pipe #(
  parameter int CH    = 4,
  parameter int W     = 5,
  parameter int DEPTH = 2
) (
  input  logic                         blif_clk_net,
  input  logic                         blif_reset_net,
  pattern_merge_pipe_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   pipe_count,
  output logic [15:0]                  sig
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic            flag;
    logic [2*CH-1:0] data;
  } pld_t;

  logic [CH-1:0]      a, b;
  logic [CH-1:0][1:0] r;
  pld_t               pld_in;
  logic [DEPTH:1]     vld_pipe, adv;
  pld_t               pld [DEPTH:1];

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pattern_merge_lane #(.W(W)) u_lane (
      .mode (bus.in_mode),
      .x    (bus.in_data[c*W +: W]),
      .a    (a[c]),
      .b    (b[c])
    );
    assign r[c] = {~(b[c] & b[(c+CH-1)%CH]), ~(a[c] | a[(c+1)%CH])};
  end

  always_comb begin
    pld_in.data = r;
    pld_in.flag = 1'b0;
    for (int c = 0; c < CH; c++) pld_in.flag = pld_in.flag | r[c][0];
  end

  // A stage may move when the consumer takes the tail or any stage at or after it has a hole.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_adv
    assign adv[k] = bus.out_ready | ~(&vld_pipe[DEPTH:k]);
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      vld_pipe <= '0;
      for (int k = 1; k <= DEPTH; k++) pld[k] <= '0;
    end else begin
      if (adv[1]) begin
        vld_pipe[1] <= bus.in_valid;
        pld[1]      <= pld_in;
      end
      for (int k = 2; k <= DEPTH; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          pld[k]      <= pld[k-1];
        end
      end
    end
  end

  always_comb begin
    pipe_count = '0;
    for (int k = 1; k <= DEPTH; k++) pipe_count = pipe_count + CW'(vld_pipe[k]);
  end

  assign bus.in_ready  = adv[1];
  assign bus.out_valid = vld_pipe[DEPTH];
  assign bus.out_data  = pld[DEPTH].data;
  assign bus.out_flag  = pld[DEPTH].flag;

`ifdef PATTERN_MERGE_MISR_EN
  logic [15:0] misr;
  logic [15:0] data_ext;

  always_comb begin
    data_ext = '0;
    data_ext[2*CH-1:0] = pld[DEPTH].data;
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net)
      misr <= '0;
    else if (bus.out_valid & bus.out_ready)
      misr <= {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]} ^ data_ext;
  end

  assign sig = misr;
`else
  assign sig = 16'h0000;
`endif
endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Scoreboard bench for pattern_merge_pipe: directed test-plan cases plus randomized traffic.
module tb_pattern_merge_pipe;
  localparam int CH = 4;
  localparam int W  = 5;
  parameter  int DEPTH = 2;
  localparam int CW = $clog2(DEPTH+1);

  typedef struct {
    logic [2*CH-1:0] d;
    logic            f;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_merge_pipe_if #(.CH(CH), .W(W)) bus ();
  logic [CW-1:0] pipe_count;
  logic [15:0]   sig;

  pattern_merge_pipe #(.CH(CH), .W(W), .DEPTH(DEPTH)) dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .bus            (bus),
    .pipe_count     (pipe_count),
    .sig            (sig)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  int   hs_in = 0;
  logic [15:0] m_sig = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: count-based reduction rules, then neighbour merge with wraparound.
  function automatic exp_t model(input logic [1:0] m, input logic [CH*W-1:0] d);
    exp_t e;
    bit   av [CH];
    bit   bv [CH];
    for (int c = 0; c < CH; c++) begin
      logic [W-1:0] x;
      int ones;
      x = d[c*W +: W];
      ones = $countones(x);
      case (m)
        2'd0: begin av[c] = (ones == 0);      bv[c] = (ones != W);                 end
        2'd1: begin av[c] = (ones % 2 == 1);  bv[c] = (x[0] == 1 && x[W-1] == 1);  end
        2'd2: begin av[c] = !(x[0] == 1 && x[1] == 1); bv[c] = (x[W-1] == 0 && x[W-2] == 0); end
        default: begin av[c] = (ones % 2 == 1); bv[c] = (ones == 0);               end
      endcase
    end
    e.f = 1'b0;
    for (int c = 0; c < CH; c++) begin
      bit r0, r1;
      r0 = !(av[c] || av[(c+1)%CH]);
      r1 = !(bv[c] && bv[(c+CH-1)%CH]);
      e.d[2*c]   = r0;
      e.d[2*c+1] = r1;
      if (r0) e.f = 1'b1;
    end
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [1:0] m, input logic [CH*W-1:0] d, input logic ordy);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_mode   = m;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    hs_in = 0;
    if (!rst && v && bus.in_ready) begin
      q.push_back(model(m, d));
      hs_in = 1;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      hs_in = 0;
      q.delete();
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    hs_in = 0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_pipe_count", 32'(pipe_count), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_sig", 32'(sig), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_flag", 32'(bus.out_flag), 0);
  endtask

  // Single transaction with out_ready held high; returns cycles until out_valid and the data seen.
  task automatic probe(input logic [1:0] m, input logic [CH*W-1:0] d, output int lat,
                       output logic [2*CH-1:0] od, output logic of);
    lat = 0; od = '0; of = 1'b0;
    cycle(1'b1, m, d, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 2'd0, '0, 1'b1);
      lat++;
      if (bus.out_valid) begin
        od = bus.out_data;
        of = bus.out_flag;
        break;
      end
    end
    cycle(1'b0, 2'd0, '0, 1'b1);
    check("single_cycle_valid", 32'(bus.out_valid), 0);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      m_sig = '0;
    end else begin
      check("pipe_count", 32'(pipe_count), 32'(q.size() - hs_in));
      check("sig", 32'(sig), 32'(m_sig));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %0h expected none (t=%0t)", bus.out_data, $time);
        end else begin
          e = q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e.d));
          check("out_flag", 32'(bus.out_flag), 32'(e.f));
`ifdef PATTERN_MERGE_MISR_EN
          m_sig = {m_sig[14:0], m_sig[15] ^ m_sig[13] ^ m_sig[12] ^ m_sig[10]} ^ 16'(e.d);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nxt, run, acc;
    logic [2*CH-1:0] od;
    logic of;
    logic ir3;
    logic [1:0]      bm [3];
    logic [CH*W-1:0] bd [3];
    logic [CH*W-1:0] ones_v;

    bus.in_valid = 1'b0; bus.in_mode = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    do_reset(3);

    ones_v = '1;
    probe(2'd0, ones_v, lat, od, of);
    check("lat_ones", 32'(lat), 32'(DEPTH));
    check("ones_data", 32'(od), 32'h0000_00FF);
    check("ones_flag", 32'(of), 1);
`ifdef PATTERN_MERGE_MISR_EN
    check("sig_after_ff", 32'(sig), 32'h0000_00FF);
`else
    check("sig_after_ff", 32'(sig), 0);
`endif
    probe(2'd1, 20'h00001, lat, od, of);
    check("lat_m1", 32'(lat), 32'(DEPTH));
    check("m1_data", 32'(od), 32'h0000_00BE);
    check("m1_flag", 32'(of), 1);
`ifdef PATTERN_MERGE_MISR_EN
    check("sig_after_be", 32'(sig), 32'h0000_0140);
`else
    check("sig_after_be", 32'(sig), 0);
`endif
    probe(2'd0, '0, lat, od, of);
    check("zero_data", 32'(od), 0);
    check("zero_flag", 32'(of), 0);

    // Backpressure: three back-to-back offers with the consumer stalled.
    for (int i = 0; i < 3; i++) begin
      bm[i] = 2'($urandom_range(0, 3));
      bd[i] = (CH*W)'($urandom());
    end
    nxt = 0; ir3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, bm[nxt], bd[nxt], 1'b0);
      if (i == 2) ir3 = bus.in_ready;
      if (hs_in != 0) nxt++;
    end
    check("bp_accepted", 32'(nxt), 32'((DEPTH < 3) ? DEPTH : 3));
    check("bp_in_ready_third", 32'(ir3), 32'(DEPTH >= 3));
    cycle(1'b0, 2'd0, '0, 1'b0);
    check("bp_pipe_count", 32'(pipe_count), 32'((DEPTH < 3) ? DEPTH : 3));
    run = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(nxt < 3, bm[(nxt < 3) ? nxt : 2], bd[(nxt < 3) ? nxt : 2], 1'b1);
      if (hs_in != 0) nxt++;
      if (bus.out_valid) run++;
      else break;
    end
    check("bp_contiguous_run", 32'(run), 3);

    // Mid-stream reset with a full pipeline; discarded items must never appear.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 2'($urandom_range(0, 3)), (CH*W)'($urandom()), 1'b0);
    cycle(1'b0, 2'd0, '0, 1'b0);
    check("full_pipe_count", 32'(pipe_count), 32'(DEPTH));
    do_reset(1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle(1'b0, 2'd0, '0, 1'b1);
      check("post_rst_idle", 32'(bus.out_valid), 0);
    end

    // Sustained streaming must accept every cycle.
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 2'($urandom_range(0, 3)), (CH*W)'($urandom()), 1'b1);
      acc += hs_in;
    end
    check("stream_rate", 32'(acc), 20);

    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), (CH*W)'($urandom()),
            $urandom_range(0, 3) != 0);

    for (int i = 0; i < 50 && q.size() != 0; i++)
      cycle(1'b0, 2'd0, '0, 1'b1);
    cycle(1'b0, 2'd0, '0, 1'b1);
    check("drained", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
